// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Purpose:
//   Bit-serial unsigned subtractor. A start request in IDLE captures the two
//   operands. RUN then processes one bit per clock, LSB first, through a
//   single full-subtractor cell, so a WIDTH-bit difference takes WIDTH
//   cycles. The finished difference and the final borrow are published in
//   one step on the last RUN edge. done pulses during the single DONE cycle
//   that follows, and the FSM then returns to IDLE.
//
// Parameters:
//   WIDTH   operand / difference width in bits (1..32)
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst_n   asynchronous active-low reset
//   start   subtraction request, only looked at in IDLE
//   a       unsigned minuend
//   b       unsigned subtrahend
//   busy    high while bits are being processed (RUN)
//   done    one-cycle pulse while the published result is fresh (DONE)
//   diff    (a - b) mod 2^WIDTH of the last completed operation
//   borrow  1 when a < b for the last completed operation
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    // The bit counter must still be at least one bit wide when WIDTH is 1.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [IDX_W-1:0] r_idx;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_ai;
    logic             w_bi;
    logic             w_d;
    logic             w_brNext;
    logic             w_last;
    logic [WIDTH-1:0] w_shNext;
    logic             w_accept;

    // The operand registers shift right once per RUN cycle.
    // Bit 0 of each is therefore always the bit currently being processed.
    assign w_ai = r_a[0];
    assign w_bi = r_b[0];

    // Full-subtractor cell. A borrow is produced when the minuend bit is 0
    // and the subtrahend bit is 1. When the two bits are equal, an incoming
    // borrow passes straight through.
    assign w_d      = w_ai ^ w_bi ^ r_br;
    assign w_brNext = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = (r_state == S_IDLE) && start;

    // The difference bits enter at the MSB and move down one place per cycle.
    // After WIDTH shifts, the first (LSB) result bit has reached bit 0.
    // The shift is written as a shift plus a bit overwrite, so the same code
    // also works when WIDTH is 1.
    always_comb begin
        w_shNext           = r_sh >> 1;
        w_shNext[WIDTH-1]  = w_d;
    end

    // Control FSM. start is only honoured in IDLE. DONE always lasts exactly
    // one cycle, so a start held high is taken again on the first edge back
    // in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start)  r_state <= S_RUN;
                S_RUN:  if (w_last) r_state <= S_DONE;
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath. Operands are frozen at the capture edge, so later changes on
    // a/b cannot affect the result. The published diff/borrow only change on
    // the last RUN edge, which means they keep showing the previous result
    // for the whole of RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_idx    <= '0;
            r_br     <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sh  <= '0;
            r_idx <= '0;
            r_br  <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_a  <= r_a >> 1;
            r_b  <= r_b >> 1;
            r_sh <= w_shNext;
            r_br <= w_brNext;
            if (w_last) begin
                r_idx    <= '0;
                r_diff   <= w_shNext;
                r_borrow <= w_brNext;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign diff   = r_diff;
    assign borrow = r_borrow;

endmodule
